// File: rtl/mem_result_responder.sv
// Store-watching result responder: ends a test run in PASS, FAIL or TIMEOUT
// based on the processor's data-memory stores, for on-board self-checking.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_RUN     | monitoring stores, counting cycles and stores
// S_PASS    | a store matched the programmed address/data pair
// S_FAIL    | STRICT build only: a non-matching store was seen
// S_TIMEOUT | run limit reached without a match
module mem_result_responder #(
    parameter int CNT_W  = 32,
    parameter int WCNT_W = 16,
    parameter int STRICT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       exp_adr,
    input  logic [31:0]       exp_data,
    input  logic [CNT_W-1:0]  timeout_cycles,
    input  logic              memwrite,
    input  logic [31:0]       dataadr,
    input  logic [31:0]       writedata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles,
    output logic [WCNT_W-1:0] write_count,
    output logic [31:0]       bad_adr,
    output logic [31:0]       bad_data,
    output logic              bad_valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        exp_adr_q, exp_adr_d;
    logic [31:0]        exp_data_q, exp_data_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               tmo_en_q, tmo_en_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [31:0]        bad_adr_q, bad_adr_d;
    logic [31:0]        bad_data_q, bad_data_d;
    logic               bad_valid_q, bad_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;

    logic               st_match;
    logic               st_mismatch;
    logic               tc_hit;

    // Remaining-cycle down-counter reaches 1 on the edge where cycles equals
    // timeout_cycles-1, so the run ends with cycles == timeout_cycles.
    always_comb begin
        st_match    = memwrite && (dataadr == exp_adr_q) && (writedata == exp_data_q);
        st_mismatch = memwrite && !st_match;
        tc_hit      = tmo_en_q && (remain_q == CNT_W'(1));

        state_d     = state_q;
        exp_adr_d   = exp_adr_q;
        exp_data_d  = exp_data_q;
        remain_d    = remain_q;
        tmo_en_d    = tmo_en_q;
        cycles_d    = cycles_q;
        wcnt_d      = wcnt_q;
        bad_adr_d   = bad_adr_q;
        bad_data_d  = bad_data_q;
        bad_valid_d = bad_valid_q;

        unique case (state_q)
            S_RUN: begin
                if (tmo_en_q) begin
                    remain_d = remain_q - CNT_W'(1);
                end
                if (cycles_q != {CNT_W{1'b1}}) begin
                    cycles_d = cycles_q + CNT_W'(1);
                end
                if (memwrite && (wcnt_q != {WCNT_W{1'b1}})) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
                if (st_mismatch && !bad_valid_q) begin
                    bad_adr_d   = dataadr;
                    bad_data_d  = writedata;
                    bad_valid_d = 1'b1;
                end
                if (st_match) begin
                    state_d = S_PASS;
                end else if ((STRICT != 0) && st_mismatch) begin
                    state_d = S_FAIL;
                end else if (tc_hit) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d     = S_RUN;
                    exp_adr_d   = exp_adr;
                    exp_data_d  = exp_data;
                    remain_d    = timeout_cycles;
                    tmo_en_d    = (timeout_cycles != '0);
                    cycles_d    = '0;
                    wcnt_d      = '0;
                    bad_adr_d   = '0;
                    bad_data_d  = '0;
                    bad_valid_d = 1'b0;
                end
            end
        endcase

        busy_d    = (state_d == S_RUN);
        pass_d    = (state_d == S_PASS);
        fail_d    = (state_d == S_FAIL);
        timeout_d = (state_d == S_TIMEOUT);
        done_d    = pass_d || fail_d || timeout_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            exp_adr_q   <= '0;
            exp_data_q  <= '0;
            remain_q    <= '0;
            tmo_en_q    <= 1'b0;
            cycles_q    <= '0;
            wcnt_q      <= '0;
            bad_adr_q   <= '0;
            bad_data_q  <= '0;
            bad_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_adr_q   <= exp_adr_d;
            exp_data_q  <= exp_data_d;
            remain_q    <= remain_d;
            tmo_en_q    <= tmo_en_d;
            cycles_q    <= cycles_d;
            wcnt_q      <= wcnt_d;
            bad_adr_q   <= bad_adr_d;
            bad_data_q  <= bad_data_d;
            bad_valid_q <= bad_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign cycles      = cycles_q;
    assign write_count = wcnt_q;
    assign bad_adr     = bad_adr_q;
    assign bad_data    = bad_data_q;
    assign bad_valid   = bad_valid_q;

endmodule

// File: tb/tb_mem_result_responder.sv
// Bench for mem_result_responder: lax and strict instances on shared stimulus,
// checked against a run-outcome model derived from the store schedule.
module tb_mem_result_responder;

    typedef struct packed {
        logic [5:0]  flags;   // {busy, done, pass, fail, timeout, bad_valid}
        logic [31:0] cyc;
        logic [15:0] wc;
        logic [31:0] badadr;
        logic [31:0] baddata;
        logic [15:0] dedge;   // edge index (after start) at which done first rose
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] exp_adr = '0;
    logic [31:0] exp_data = '0;
    logic [31:0] timeout_cycles = '0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;

    logic        l_busy, l_done, l_pass, l_fail, l_timeout, l_bad_valid;
    logic [31:0] l_cycles, l_bad_adr, l_bad_data;
    logic [15:0] l_write_count;
    logic        s_busy, s_done, s_pass, s_fail, s_timeout, s_bad_valid;
    logic [31:0] s_cycles, s_bad_adr, s_bad_data;
    logic [15:0] s_write_count;

    always #5 clk = ~clk;

    mem_result_responder #(.CNT_W(32), .WCNT_W(16), .STRICT(0)) dut_lax (
        .clk(clk), .reset(reset), .start(start),
        .exp_adr(exp_adr), .exp_data(exp_data), .timeout_cycles(timeout_cycles),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(l_busy), .done(l_done), .pass(l_pass), .fail(l_fail), .timeout(l_timeout),
        .cycles(l_cycles), .write_count(l_write_count),
        .bad_adr(l_bad_adr), .bad_data(l_bad_data), .bad_valid(l_bad_valid)
    );

    mem_result_responder #(.CNT_W(32), .WCNT_W(16), .STRICT(1)) dut_str (
        .clk(clk), .reset(reset), .start(start),
        .exp_adr(exp_adr), .exp_data(exp_data), .timeout_cycles(timeout_cycles),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
        .cycles(s_cycles), .write_count(s_write_count),
        .bad_adr(s_bad_adr), .bad_data(s_bad_data), .bad_valid(s_bad_valid)
    );

    int checks = 0;
    int errors = 0;

    bit          sw_en [128];
    logic [31:0] sw_adr[128];
    logic [31:0] sw_dat[128];
    bit          sw_st [128];

    obs_t l_after, s_after, l_fin, s_fin;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t get_obs(input bit strict);
        obs_t o;
        o = '0;
        if (strict) begin
            o.flags   = {s_busy, s_done, s_pass, s_fail, s_timeout, s_bad_valid};
            o.cyc     = s_cycles;
            o.wc      = s_write_count;
            o.badadr  = s_bad_adr;
            o.baddata = s_bad_data;
        end else begin
            o.flags   = {l_busy, l_done, l_pass, l_fail, l_timeout, l_bad_valid};
            o.cyc     = l_cycles;
            o.wc      = l_write_count;
            o.badadr  = l_bad_adr;
            o.baddata = l_bad_data;
        end
        return o;
    endfunction

    function automatic obs_t mk(input logic [5:0] f, input int c, input int w,
                                input logic [31:0] ba, input logic [31:0] bd, input int de);
        obs_t o;
        o.flags = f; o.cyc = 32'(c); o.wc = 16'(w);
        o.badadr = ba; o.baddata = bd; o.dedge = 16'(de);
        return o;
    endfunction

    // Outcome of one run from the store schedule: store k is seen on RUN
    // edge k+1; the run ends on the first match, strict mismatch or limit.
    function automatic obs_t model(input logic [31:0] ea, input logic [31:0] ed,
                                   input int t, input int n, input bit strict);
        obs_t e;
        int endk, last, wc;
        bit m, mm, got_bad, busy_o, pass_o, fail_o, tmo_o;
        e = '0; endk = -1; wc = 0; got_bad = 0;
        busy_o = 0; pass_o = 0; fail_o = 0; tmo_o = 0;
        for (int k = 0; k < n; k++) begin
            m  = sw_en[k] && (sw_adr[k] == ea) && (sw_dat[k] == ed);
            mm = sw_en[k] && !m;
            if (m || (strict && mm) || (t != 0 && k == t - 1)) begin
                endk = k;
                if (m) pass_o = 1;
                else if (strict && mm) fail_o = 1;
                else tmo_o = 1;
                break;
            end
        end
        last = (endk >= 0) ? endk : n - 1;
        for (int k = 0; k <= last; k++) begin
            if (sw_en[k]) begin
                wc++;
                if (!got_bad && !((sw_adr[k] == ea) && (sw_dat[k] == ed))) begin
                    got_bad   = 1;
                    e.badadr  = sw_adr[k];
                    e.baddata = sw_dat[k];
                end
            end
        end
        busy_o  = (endk < 0);
        e.flags = {busy_o, !busy_o, pass_o, fail_o, tmo_o, got_bad};
        e.cyc   = 32'(last + 1);
        e.wc    = 16'(wc);
        e.dedge = (endk >= 0) ? 16'(endk + 1) : 16'd0;
        return e;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < 128; k++) begin
            sw_en[k] = 0; sw_adr[k] = '0; sw_dat[k] = '0; sw_st[k] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; memwrite = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic run(input logic [31:0] ea, input logic [31:0] ed, input int t,
                       input int n, input bit store_at_start);
        int lde, sde;
        lde = 0; sde = 0;
        exp_adr = ea; exp_data = ed; timeout_cycles = 32'(t); start = 1'b1;
        memwrite = store_at_start; dataadr = ea; writedata = ed;
        tick();
        l_after = get_obs(0);
        s_after = get_obs(1);
        start = 1'b0; memwrite = 1'b0;
        exp_adr = $urandom; exp_data = $urandom; timeout_cycles = $urandom;
        for (int k = 0; k < n; k++) begin
            memwrite = sw_en[k]; dataadr = sw_adr[k]; writedata = sw_dat[k]; start = sw_st[k];
            tick();
            if (l_done && lde == 0) lde = k + 1;
            if (s_done && sde == 0) sde = k + 1;
        end
        memwrite = 1'b0; start = 1'b0;
        l_fin = get_obs(0); l_fin.dedge = 16'(lde);
        s_fin = get_obs(1); s_fin.dedge = 16'(sde);
    endtask

    task automatic test_reset();
        obs_t z;
        z = '0;
        reset = 1'b0; start = 1'b1; exp_adr = 32'd18; exp_data = 32'd21; timeout_cycles = 32'd5;
        tick(); tick();
        start = 1'b0;
        checks++;
        if (get_obs(0) !== z) begin errors++; $display("FAIL reset_lax got %h want %h", get_obs(0), z); end
        checks++;
        if (get_obs(1) !== z) begin errors++; $display("FAIL reset_strict got %h want %h", get_obs(1), z); end
        reset = 1'b1;
        tick();
        checks++;
        if (get_obs(0) !== z) begin errors++; $display("FAIL reset_idle got %h want %h", get_obs(0), z); end
    endtask

    task automatic test_basic_pass();
        obs_t e;
        clear_stim();
        sw_en[2]  = 1; sw_adr[2]  = 32'd4;  sw_dat[2]  = 32'd7;
        sw_en[5]  = 1; sw_adr[5]  = 32'd8;  sw_dat[5]  = 32'd9;
        sw_en[10] = 1; sw_adr[10] = 32'd18; sw_dat[10] = 32'd21;
        run(32'd18, 32'd21, 200, 20, 0);
        e = mk(6'b011001, 11, 3, 32'd4, 32'd7, 11);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL basic_pass_lax got %h want %h", l_fin, e); end
        e = mk(6'b010101, 3, 1, 32'd4, 32'd7, 3);
        checks++;
        if (s_fin !== e) begin errors++; $display("FAIL basic_pass_strict got %h want %h", s_fin, e); end
        e = model(32'd18, 32'd21, 200, 20, 0);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL basic_pass_model got %h want %h", l_fin, e); end
    endtask

    task automatic test_restart();
        obs_t e;
        clear_stim();
        sw_st[1] = 1; sw_st[2] = 1;
        sw_en[7] = 1; sw_adr[7] = 32'd3; sw_dat[7] = 32'd3;
        run(32'd3, 32'd3, 100, 15, 1);
        e = mk(6'b100000, 0, 0, 32'd0, 32'd0, 0);
        checks++;
        if (l_after !== e) begin errors++; $display("FAIL restart_clear_lax got %h want %h", l_after, e); end
        checks++;
        if (s_after !== e) begin errors++; $display("FAIL restart_clear_strict got %h want %h", s_after, e); end
        e = mk(6'b011000, 8, 1, 32'd0, 32'd0, 8);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL restart_pass_lax got %h want %h", l_fin, e); end
        checks++;
        if (s_fin !== e) begin errors++; $display("FAIL restart_pass_strict got %h want %h", s_fin, e); end
    endtask

    task automatic test_timeout();
        obs_t e;
        clear_stim();
        run(32'd84, 32'd7, 50, 60, 0);
        e = mk(6'b010010, 50, 0, 32'd0, 32'd0, 50);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL timeout_lax got %h want %h", l_fin, e); end
        checks++;
        if (s_fin !== e) begin errors++; $display("FAIL timeout_strict got %h want %h", s_fin, e); end
    endtask

    task automatic test_coincident();
        obs_t e;
        clear_stim();
        sw_en[19] = 1; sw_adr[19] = 32'd84; sw_dat[19] = 32'd7;
        run(32'd84, 32'd7, 20, 25, 0);
        e = mk(6'b011000, 20, 1, 32'd0, 32'd0, 20);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL coinc_pass_lax got %h want %h", l_fin, e); end
        checks++;
        if (s_fin !== e) begin errors++; $display("FAIL coinc_pass_strict got %h want %h", s_fin, e); end
        sw_dat[19] = 32'd8;
        run(32'd84, 32'd7, 20, 25, 0);
        e = mk(6'b010011, 20, 1, 32'd84, 32'd8, 20);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL coinc_tmo_lax got %h want %h", l_fin, e); end
        e = mk(6'b010101, 20, 1, 32'd84, 32'd8, 20);
        checks++;
        if (s_fin !== e) begin errors++; $display("FAIL coinc_fail_strict got %h want %h", s_fin, e); end
    endtask

    task automatic test_strict_mismatch();
        obs_t e;
        logic [31:0] a;
        a = 32'h70f0_0ff0;
        clear_stim();
        sw_en[3] = 1; sw_adr[3] = a; sw_dat[3] = 32'd3;
        sw_en[6] = 1; sw_adr[6] = a; sw_dat[6] = 32'd2;
        run(a, 32'd2, 100, 12, 0);
        e = mk(6'b010101, 4, 1, a, 32'd3, 4);
        checks++;
        if (s_fin !== e) begin errors++; $display("FAIL strict_fail got %h want %h", s_fin, e); end
        e = mk(6'b011001, 7, 2, a, 32'd3, 7);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL strict_lax_pass got %h want %h", l_fin, e); end
    endtask

    task automatic test_timeout_bounds();
        obs_t e;
        clear_stim();
        run(32'd84, 32'd7, 1, 5, 0);
        e = mk(6'b010010, 1, 0, 32'd0, 32'd0, 1);
        checks++;
        if (l_fin !== e) begin errors++; $display("FAIL tmo_one_lax got %h want %h", l_fin, e); end
        run(32'd84, 32'd7, 0, 80, 0);
        e = mk(6'b100000, 80, 0, 32'd0, 32'd0, 0);
        checks++;
        if (s_fin !== e) begin errors++; $display("FAIL tmo_zero_strict got %h want %h", s_fin, e); end
        do_reset();
    endtask

    task automatic test_reset_mid_run();
        obs_t z;
        z = '0;
        clear_stim();
        run(32'd18, 32'd21, 200, 5, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (get_obs(0) !== z) begin errors++; $display("FAIL midrun_reset got %h want %h", get_obs(0), z); end
        memwrite = 1'b1; dataadr = 32'd18; writedata = 32'd21;
        for (int k = 0; k < 4; k++) tick();
        memwrite = 1'b0;
        checks++;
        if (get_obs(0) !== z) begin errors++; $display("FAIL midrun_ignore_lax got %h want %h", get_obs(0), z); end
        checks++;
        if (get_obs(1) !== z) begin errors++; $display("FAIL midrun_ignore_strict got %h want %h", get_obs(1), z); end
    endtask

    task automatic test_random();
        obs_t el, es;
        logic [31:0] ea, ed;
        int t, n, sel;
        bit prev_busy;
        prev_busy = 0;
        for (int it = 0; it < 30; it++) begin
            if (prev_busy) do_reset();
            ea = $urandom; ed = $urandom;
            t = $urandom_range(0, 40);
            n = $urandom_range(1, 60);
            clear_stim();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    sw_en[k] = 1;
                    sel = $urandom_range(0, 5);
                    case (sel)
                        0: begin sw_adr[k] = ea; sw_dat[k] = ed; end
                        1: begin sw_adr[k] = ea; sw_dat[k] = ed ^ (32'd1 << $urandom_range(0, 31)); end
                        2: begin sw_adr[k] = ea ^ (32'd1 << $urandom_range(0, 31)); sw_dat[k] = ed; end
                        default: begin sw_adr[k] = $urandom; sw_dat[k] = $urandom; end
                    endcase
                end
            end
            run(ea, ed, t, n, ($urandom_range(0, 3) == 0));
            el = model(ea, ed, t, n, 0);
            es = model(ea, ed, t, n, 1);
            checks++;
            if (l_fin !== el) begin errors++; $display("FAIL random_lax it=%0d got %h want %h", it, l_fin, el); end
            checks++;
            if (s_fin !== es) begin errors++; $display("FAIL random_strict it=%0d got %h want %h", it, s_fin, es); end
            prev_busy = el.flags[5] || es.flags[5];
        end
    endtask

    initial begin
        clear_stim();
        test_reset();
        test_basic_pass();
        test_restart();
        test_timeout();
        test_coincident();
        test_strict_mismatch();
        test_timeout_bounds();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
